// File: rtl/pc_gen.sv
// pc_gen - fetch-stage program counter with prioritised redirect, stall,
// exception vectoring and a circular return-address stack (RAS).
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   -> adel_f flags misaligned or out-of-window fetch addresses
//   undefined -> adel_f tied to 0, IM_BASE / IM_BYTES unused
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   en_pc          1 = advance/redirect, 0 = stall
//   pc_op          next-PC select (0 NORMAL,1 BRANCH,2 JAL,3 JR,4 RET,5 ERET; 6/7 = NORMAL)
//   branch_target  taken-branch target
//   jal_target     j/jal target
//   jr_target      register target, also RET fallback when the RAS is empty
//   epc_in         ERET return address
//   exc_req        exception redirect to EXC_PC (overrides stall)
//   ras_push       push push_data onto the RAS
//   push_data      link address to push
//   pc_f           registered fetch PC
//   pc_plus4       pc_f + 4
//   ras_top        top RAS entry, 0 when empty
//   ras_count      number of valid RAS entries
//   ras_empty      ras_count == 0
//   ras_full       ras_count == RAS_DEPTH
//   adel_f         fetch address error flag
module pc_gen #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_PC  = 32'h0000_3000,
  parameter logic [WIDTH-1:0]   EXC_PC    = 32'h0000_4180,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0]   IM_BASE   = 32'h0000_3000,
  parameter logic [WIDTH-1:0]   IM_BYTES  = 32'h0000_4000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en_pc,
  input  logic [2:0]                     pc_op,
  input  logic [WIDTH-1:0]               branch_target,
  input  logic [WIDTH-1:0]               jal_target,
  input  logic [WIDTH-1:0]               jr_target,
  input  logic [WIDTH-1:0]               epc_in,
  input  logic                           exc_req,
  input  logic                           ras_push,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               pc_f,
  output logic [WIDTH-1:0]               pc_plus4,
  output logic [WIDTH-1:0]               ras_top,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           adel_f
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    OP_NORMAL = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JAL    = 3'd2,
    OP_JR     = 3'd3,
    OP_RET    = 3'd4,
    OP_ERET   = 3'd5
  } pc_op_t;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] next_pc;
  logic             ras_qual;
  logic             do_push;
  logic             do_pop;

  assign pc_plus4  = pc_f + WIDTH'(4);
  assign ras_count = count;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CW'(RAS_DEPTH));
  assign ras_top   = ras_empty ? '0 : ras_mem[ptr];

  // Neither a stalled nor an exception cycle may disturb the RAS.
  assign ras_qual = en_pc && !exc_req;
  assign do_push  = ras_qual && ras_push;
  assign do_pop   = ras_qual && (pc_op == OP_RET) && !ras_empty;

  always_comb begin
    next_pc = pc_f;
    if (exc_req) begin
      next_pc = EXC_PC;
    end else if (en_pc) begin
      case (pc_op)
        OP_BRANCH: next_pc = branch_target;
        OP_JAL:    next_pc = jal_target;
        OP_JR:     next_pc = jr_target;
        OP_RET:    next_pc = ras_empty ? jr_target : ras_top;
        OP_ERET:   next_pc = epc_in;
        default:   next_pc = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= next_pc;
    end
  end

  // Circular stack: ptr addresses the top entry. When full, a push lands on
  // the oldest slot (ptr+1 wraps onto it) and the count saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_mem[i] <= '0;
      end
    end else begin
      if (do_push && do_pop) begin
        ras_mem[ptr] <= push_data;
      end else if (do_push) begin
        ras_mem[ptr + PW'(1)] <= push_data;
        ptr <= ptr + PW'(1);
        if (!ras_full) begin
          count <= count + CW'(1);
        end
      end else if (do_pop) begin
        ptr   <= ptr - PW'(1);
        count <= count - CW'(1);
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Window limit computed one bit wider so IM_BASE + IM_BYTES cannot wrap.
  localparam logic [WIDTH:0] IM_LIMIT = {1'b0, IM_BASE} + {1'b0, IM_BYTES};

  assign adel_f = (pc_f[1:0] != 2'b00) ||
                  (pc_f < IM_BASE) ||
                  ({1'b0, pc_f} >= IM_LIMIT);
`else
  logic [WIDTH-1:0] unused_im_window;
  assign unused_im_window = IM_BASE ^ IM_BYTES;
  assign adel_f = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_pc;
  logic [2:0]  pc_op;
  logic [31:0] branch_target, jal_target, jr_target, epc_in;
  logic        exc_req;
  logic        ras_push;
  logic [31:0] push_data;
  logic [31:0] pc_f, pc_plus4, ras_top;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, adel_f;

  int passed = 0;
  int total  = 0;

  // Reference model: PC value plus the RAS as a bounded queue (back = top).
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .clk(clk), .reset(reset), .en_pc(en_pc), .pc_op(pc_op),
    .branch_target(branch_target), .jal_target(jal_target),
    .jr_target(jr_target), .epc_in(epc_in), .exc_req(exc_req),
    .ras_push(ras_push), .push_data(push_data), .pc_f(pc_f),
    .pc_plus4(pc_plus4), .ras_top(ras_top), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .adel_f(adel_f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        exc;
    logic [2:0]  op;
    logic        push;
    logic [31:0] tgt;
    logic [31:0] pd;
    logic [31:0] exp_pc;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic en, logic exc, logic [2:0] op, logic push,
                              logic [31:0] tgt, logic [31:0] pd,
                              logic [31:0] exp_pc, logic [2:0] exp_cnt);
    vec_t v;
    v.en = en; v.exc = exc; v.op = op; v.push = push;
    v.tgt = tgt; v.pd = pd; v.exp_pc = exp_pc; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Only the selected target carries tgt; the others get distinct junk so a
  // wrong mux leg shows up as a wrong pc_f.
  task automatic drive(logic en, logic exc, logic [2:0] op, logic push,
                       logic [31:0] tgt, logic [31:0] pd);
    en_pc         = en;
    exc_req       = exc;
    pc_op         = op;
    ras_push      = push;
    push_data     = pd;
    branch_target = (op == 3'd1) ? tgt : 32'hbad0_0010;
    jal_target    = (op == 3'd2) ? tgt : 32'hbad0_0020;
    jr_target     = (op == 3'd3 || op == 3'd4) ? tgt : 32'hbad0_0030;
    epc_in        = (op == 3'd5) ? tgt : 32'hbad0_0050;
  endtask

  function automatic logic [31:0] m_top();
    return (m_ras.size() == 0) ? 32'h0 : m_ras[m_ras.size()-1];
  endfunction

  function automatic logic m_adel(logic [31:0] pc);
`ifdef PC_ALIGN_CHECK_EN
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc >= 32'h7000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_pc = 32'h3000;
    m_ras.delete();
  endtask

  // Applies the architectural rules to the inputs currently on the pins.
  task automatic m_step();
    logic        nonempty;
    logic        pop;
    logic        push;
    nonempty = (m_ras.size() != 0);
    if (exc_req) begin
      m_pc = 32'h4180;
    end else if (en_pc) begin
      case (pc_op)
        3'd1: m_pc = branch_target;
        3'd2: m_pc = jal_target;
        3'd3: m_pc = jr_target;
        3'd4: m_pc = nonempty ? m_top() : jr_target;
        3'd5: m_pc = epc_in;
        default: m_pc = m_pc + 32'd4;
      endcase
      pop  = (pc_op == 3'd4) && nonempty;
      push = ras_push;
      if (push && pop) begin
        m_ras[m_ras.size()-1] = push_data;
      end else if (push) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(push_data);
      end else if (pop) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic m_check(string tag);
    chk({tag, " pc_f"},      pc_f, m_pc);
    chk({tag, " pc_plus4"},  pc_plus4, m_pc + 32'd4);
    chk({tag, " ras_top"},   ras_top, m_top());
    chk({tag, " ras_count"}, 32'(ras_count), 32'(m_ras.size()));
    chk({tag, " ras_empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
    chk({tag, " ras_full"},  32'(ras_full), 32'(m_ras.size() == DEPTH));
    chk({tag, " adel_f"},    32'(adel_f), 32'(m_adel(m_pc)));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    m_check("in_reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_check("post_reset");
    chk("reset pc_f", pc_f, 32'h3000);

    // Directed table: hand-computed pc_f and ras_count after each edge.
    vq.push_back(mk(1,0,0,0,32'h0,32'h0,32'h3004,0));
    vq.push_back(mk(1,0,0,0,32'h0,32'h0,32'h3008,0));
    vq.push_back(mk(1,0,0,0,32'h0,32'h0,32'h300c,0));
    vq.push_back(mk(1,0,0,0,32'h0,32'h0,32'h3010,0));
    vq.push_back(mk(0,0,0,0,32'h0,32'h0,32'h3010,0));
    vq.push_back(mk(0,0,0,0,32'h0,32'h0,32'h3010,0));
    vq.push_back(mk(0,1,0,1,32'h0,32'h3999,32'h4180,0));
    vq.push_back(mk(1,0,1,0,32'h3100,32'h0,32'h3100,0));
    vq.push_back(mk(1,0,2,0,32'h3200,32'h0,32'h3200,0));
    vq.push_back(mk(1,0,3,0,32'h3300,32'h0,32'h3300,0));
    vq.push_back(mk(1,0,5,0,32'h3050,32'h0,32'h3050,0));
    vq.push_back(mk(1,0,4,0,32'h3500,32'h0,32'h3500,0));
    vq.push_back(mk(1,0,6,0,32'h0,32'h0,32'h3504,0));
    vq.push_back(mk(1,0,7,0,32'h0,32'h0,32'h3508,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,0,1,32'h0,32'h3a00 + 32'(4*i),
                      32'h350c + 32'(4*i), 3'((i < 4) ? i+1 : 4)));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(1,0,4,0,32'h3600,32'h0,32'h3a10 - 32'(4*i), 3'(3-i)));
    vq.push_back(mk(1,0,4,0,32'h3500,32'h0,32'h3500,0));
    vq.push_back(mk(1,0,0,1,32'h0,32'h3b00,32'h3504,1));
    vq.push_back(mk(1,0,0,1,32'h0,32'h3b04,32'h3508,2));
    vq.push_back(mk(1,0,4,1,32'h3600,32'h3c00,32'h3b04,2));
    vq.push_back(mk(1,0,4,0,32'h3600,32'h0,32'h3c00,1));
    vq.push_back(mk(1,0,4,0,32'h3600,32'h0,32'h3b00,0));
    vq.push_back(mk(1,0,0,1,32'h0,32'h3d00,32'h3b04,1));
    vq.push_back(mk(1,1,4,1,32'h3600,32'h3e00,32'h4180,1));
    vq.push_back(mk(0,0,4,1,32'h3600,32'h3e00,32'h4180,1));
    vq.push_back(mk(1,0,4,0,32'h3600,32'h0,32'h3d00,0));
    vq.push_back(mk(1,0,3,0,32'hffff_fffc,32'h0,32'hffff_fffc,0));
    vq.push_back(mk(1,0,0,0,32'h0,32'h0,32'h0000_0000,0));
    vq.push_back(mk(1,0,3,0,32'h3002,32'h0,32'h3002,0));
    vq.push_back(mk(1,0,3,0,32'h7000,32'h0,32'h7000,0));
    vq.push_back(mk(1,0,3,0,32'h3ffc,32'h0,32'h3ffc,0));

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].exc, vq[i].op, vq[i].push, vq[i].tgt, vq[i].pd);
      cycle();
      chk($sformatf("vec%0d pc_f", i), pc_f, vq[i].exp_pc);
      chk($sformatf("vec%0d ras_count", i), 32'(ras_count), 32'(vq[i].exp_cnt));
      m_check($sformatf("vec%0d", i));
    end

    // Top entry after simultaneous push+pop must be the pushed value.
    drive(1'b1, 1'b0, 3'd0, 1'b1, 32'h0, 32'h3b00); cycle();
    drive(1'b1, 1'b0, 3'd0, 1'b1, 32'h0, 32'h3b04); cycle();
    drive(1'b1, 1'b0, 3'd4, 1'b1, 32'h3600, 32'h3c00); cycle();
    chk("simul pc_f", pc_f, 32'h3b04);
    chk("simul top", ras_top, 32'h3c00);
    chk("simul count", 32'(ras_count), 32'd2);
    m_check("simul");

    // Randomised run with an asynchronous reset dropped in mid-cycle.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, op,
            $urandom_range(0, 2) == 0,
            32'h3000 + (32'($urandom_range(0, 32'hfff)) << 2),
            32'h3000 + (32'($urandom_range(0, 32'hfff)) << 2));
      if (n == 200) begin
        drive(1'b1, 1'b0, 3'd1, 1'b1, 32'h3abc, 32'h3def);
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        m_check("async_reset");
        @(posedge clk);
        #1;
        m_check("held_reset");
        reset = 1'b1;
      end else begin
        cycle();
        m_check($sformatf("rand%0d", n));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
